keypad_scanner: RTL
===================

# keypad_scanner

Front-end input stage for the Chicken Cha-Cha-Cha board: scans a 4x4 active-low matrix keypad, debounces it and a raw start button, and presents clean levels to the game control unit. The control unit consumes `key` (4'hF = no key held) and `c` (start request). All outputs are registered in the `clk` domain.

## Interface

Parameters:
- `SCAN_DIV`, 1000: clk cycles each column is driven; must be ≥ 4.
- `DEBOUNCE`, 4: consecutive identical scan frames needed to accept a change; must be ≥ 1.

Ports:
- `clk`  in  1  system clock.
- `rst`  in  1  reset, synchronous, active-high.
- `row_in`  in  4  raw keypad rows, active-low (pulled up), asynchronous.
- `start_btn`  in  1  raw start button, active-high, asynchronous.
- `col_out`  out  4  column drive, one-cold (active-low).
- `key`  out  4  debounced key code; 4'hF = no key.
- `key_valid`  out  1  one-cycle strobe when `key` changes to a non-F code.
- `c`  out  1  one-cycle start pulse on a debounced start-button press.

## Operation

- **Synchronisers:** `row_in` and `start_btn` each pass through two flops before use.
- **Column scan:**
  - A slot counter (width clog2(SCAN_DIV)) counts 0..SCAN_DIV-1.
  - A column index counts 0..3 and advances, wrapping 3→0, when the slot counter wraps.
  - `col_out` = ~(4'b0001 << column).
- **Row sampling:**
  - At slot count SCAN_DIV-1, the synchronised rows for the current column are sampled.
  - A row bit that is 0 marks key code {row[1:0], col[1:0]}.
  - Code 4'hF (row 3, column 3) is ignored and never reported.
- **Frame code:**
  - A frame is the four column slots, from column 0 through column 3.
  - The frame's raw code is the lowest pressed code, or 4'hF if none is pressed.
  - The start button's raw level is taken from its synchronised value at the same frame-end sample.
- **Key debounce (evaluated at each frame end):**
  - If raw equals the previous frame's raw, the stable count increments, saturating at DEBOUNCE.
  - Otherwise the stable count is set to 1 and the previous raw is updated.
  - When the stable count equals DEBOUNCE and raw ≠ `key`, `key` takes raw.
  - If the new `key` ≠ F, `key_valid` pulses for one cycle.
  - Release is accepted on the same DEBOUNCE rule; it returns `key` to F with no strobe.
- **Start debounce:**
  - Same DEBOUNCE rule, applied to the start level; yields `start_db`.
  - `c` pulses for one cycle on a 0→1 transition of `start_db`.
  - Holding the button produces no further pulses.
- **Direct key change:** a direct change (A held, then B held with no release) is accepted after DEBOUNCE frames of B and strobes `key_valid` again.

## Timing

- **Reset values:**
  - `col_out` = 4'b1110; `key` = 4'hF; `key_valid` = 0; `c` = 0.
  - Slot and column counters = 0.
  - Previous raw = F; stable counts = 0; `start_db` = 0.
- **Frame period:** 4·SCAN_DIV cycles.
- **Output update:** `key`, `key_valid` and `c` update on the edge after the frame-end sample (slot SCAN_DIV-1 of column 3).
- **Press latency:** DEBOUNCE complete frames of stable contact + 2 sync cycles + 1 cycle.
  - A contact beginning mid-frame counts only from the first frame in which every relevant sample sees it.
- **Glitch rejection:** glitches shorter than DEBOUNCE frames never change `key` or produce `c`.
- **Strobe width:** `key_valid` and `c` are high exactly one cycle, never on consecutive cycles from one event.
- **Concurrent events:** a key strobe and a start pulse may occur in the same cycle; they are independent.
- **Reset mid-scan or mid-press:** all state returns to reset values on the next edge. A still-held key must be re-debounced for a full DEBOUNCE frames before it is reported again.

## Test plan

All scenarios use SCAN_DIV=4, DEBOUNCE=2 (frame = 16 cycles).

1. **Reset:** assert `rst` 3 cycles → `col_out`=1110, `key`=F, `key_valid`=0, `c`=0. After release, `col_out` steps 1110→1101→1011→0111 every 4 cycles and then wraps.
2. **Press and release:**
   - Hold key 5 (row 1 driven low when column 1 is active) for 5 frames → `key`=5 after the 2nd full stable frame, with exactly one `key_valid` pulse; `key` stays 5.
   - Release → `key`=F after 2 frames, with no strobe.
3. **Bounce:** hold key 3 for 1 frame, then release → `key` stays F and `key_valid` never asserts.
4. **Multiple keys and direct change:**
   - Press 6 and 9 together → `key`=6.
   - Then release 6 while holding 9 → `key`=9 after 2 frames, with a second `key_valid` pulse.
5. **Start button:** hold `start_btn` for 4 frames → exactly one `c` pulse, 2 frames after onset. A 1-frame tap → no pulse.
6. **Ignored code and reset mid-press:**
   - Press row 3 / column 3 → `key` stays F.
   - Hold key A until `key`=A, then pulse `rst` → `key`=F the next cycle; `key` returns to A with a strobe only after 2 more full frames.

Source files
------------

// File: rtl/keypad_scanner.sv
// Front-end input stage: scans a 4x4 active-low keypad, debounces the key code
// and the raw start button per scan frame, and emits clean levels and strobes.
module keypad_scanner #(
  parameter int unsigned SCAN_DIV = 1000,
  parameter int unsigned DEBOUNCE = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] row_in,
  input  logic       start_btn,
  output logic [3:0] col_out,
  output logic [3:0] key,
  output logic       key_valid,
  output logic       c
);

  localparam int unsigned SW = $clog2(SCAN_DIV);
  localparam int unsigned DW = $clog2(DEBOUNCE + 1);
  localparam logic [SW-1:0] SLOT_LAST = SW'(SCAN_DIV - 1);
  localparam logic [DW-1:0] CNT_MAX   = DW'(DEBOUNCE);
  localparam logic [3:0]    NO_KEY    = 4'hF;

  logic [3:0]    row_s1_q, row_s2_q;
  logic          start_s1_q, start_s2_q;
  logic [SW-1:0] slot_q, slot_d;
  logic [1:0]    col_q, col_d;
  logic [3:0]    col_out_q;
  logic [3:0]    acc_q, acc_d;
  logic [3:0]    key_prev_q, key_prev_d;
  logic [DW-1:0] key_cnt_q, key_cnt_d;
  logic [3:0]    key_q, key_d;
  logic          key_valid_q, key_valid_d;
  logic          st_prev_q, st_prev_d;
  logic [DW-1:0] st_cnt_q, st_cnt_d;
  logic          st_db_q, st_db_d;
  logic          c_q, c_d;

  logic          sample, frame_end;
  logic [3:0]    masked_rows, col_code, frame_raw;

  always_comb begin
    sample    = (slot_q == SLOT_LAST);
    frame_end = sample && (col_q == 2'd3);

    // Row 3 of column 3 would encode 4'hF, which is reserved for "no key".
    masked_rows = row_s2_q | ((col_q == 2'd3) ? 4'b1000 : 4'b0000);
    casez (masked_rows)
      4'b???0: col_code = {2'd0, col_q};
      4'b??01: col_code = {2'd1, col_q};
      4'b?011: col_code = {2'd2, col_q};
      4'b0111: col_code = {2'd3, col_q};
      default: col_code = NO_KEY;
    endcase
    frame_raw = (col_code < acc_q) ? col_code : acc_q;

    slot_d      = sample ? '0 : slot_q + SW'(1);
    col_d       = sample ? col_q + 2'd1 : col_q;
    acc_d       = acc_q;
    key_prev_d  = key_prev_q;
    key_cnt_d   = key_cnt_q;
    key_d       = key_q;
    key_valid_d = 1'b0;
    st_prev_d   = st_prev_q;
    st_cnt_d    = st_cnt_q;
    st_db_d     = st_db_q;
    c_d         = 1'b0;

    if (sample) begin
      acc_d = frame_end ? NO_KEY : frame_raw;
    end

    if (frame_end) begin
      if (frame_raw == key_prev_q) begin
        if (key_cnt_q != CNT_MAX) key_cnt_d = key_cnt_q + DW'(1);
      end else begin
        key_cnt_d  = DW'(1);
        key_prev_d = frame_raw;
      end
      if (key_cnt_d == CNT_MAX && frame_raw != key_q) begin
        key_d       = frame_raw;
        key_valid_d = (frame_raw != NO_KEY);
      end

      if (start_s2_q == st_prev_q) begin
        if (st_cnt_q != CNT_MAX) st_cnt_d = st_cnt_q + DW'(1);
      end else begin
        st_cnt_d  = DW'(1);
        st_prev_d = start_s2_q;
      end
      if (st_cnt_d == CNT_MAX && start_s2_q != st_db_q) begin
        st_db_d = start_s2_q;
        c_d     = start_s2_q;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      row_s1_q    <= '1;
      row_s2_q    <= '1;
      start_s1_q  <= 1'b0;
      start_s2_q  <= 1'b0;
      slot_q      <= '0;
      col_q       <= '0;
      col_out_q   <= 4'b1110;
      acc_q       <= NO_KEY;
      key_prev_q  <= NO_KEY;
      key_cnt_q   <= '0;
      key_q       <= NO_KEY;
      key_valid_q <= 1'b0;
      st_prev_q   <= 1'b0;
      st_cnt_q    <= '0;
      st_db_q     <= 1'b0;
      c_q         <= 1'b0;
    end else begin
      row_s1_q    <= row_in;
      row_s2_q    <= row_s1_q;
      start_s1_q  <= start_btn;
      start_s2_q  <= start_s1_q;
      slot_q      <= slot_d;
      col_q       <= col_d;
      col_out_q   <= ~(4'b0001 << col_d);
      acc_q       <= acc_d;
      key_prev_q  <= key_prev_d;
      key_cnt_q   <= key_cnt_d;
      key_q       <= key_d;
      key_valid_q <= key_valid_d;
      st_prev_q   <= st_prev_d;
      st_cnt_q    <= st_cnt_d;
      st_db_q     <= st_db_d;
      c_q         <= c_d;
    end
  end

  assign col_out   = col_out_q;
  assign key       = key_q;
  assign key_valid = key_valid_q;
  assign c         = c_q;

endmodule
